// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART TX datapath: frame sequencer states and
// output-mux select codes used by the mux, serializer and sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  // Total bit slots from start bit to the end of the stop bit.
  function automatic int frame_slots(input int data_width, input logic with_parity);
    return data_width + 2 + (with_parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: walks start / data / optional parity / stop slots,
// one slot per clk, and strobes the serializer and parity calculator.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_load,
  output logic       ser_shift,
  output logic       par_load,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  tx_state_e            state, state_next;
  logic [CNT_WIDTH-1:0] bit_cnt, bit_cnt_next;
  logic                 par_en_q, par_en_next;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      par_en_q <= par_en_next;
    end
  end

  // A new byte is taken only from IDLE or STOP, and never while reset is asserted.
  assign accept = data_valid && !rst && ((state == IDLE) || (state == STOP));

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    par_en_next  = par_en_q;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    par_load     = 1'b0;
    mux_sel      = MUX_STOP;
    busy         = 1'b0;

    if (accept) begin
      ser_load    = 1'b1;
      par_load    = 1'b1;
      par_en_next = par_en;
    end

    case (state)
      IDLE: begin
        state_next = accept ? START : IDLE;
      end
      START: begin
        mux_sel      = MUX_START;
        busy         = 1'b1;
        bit_cnt_next = '0;
        state_next   = DATA;
      end
      DATA: begin
        mux_sel   = MUX_DATA;
        busy      = 1'b1;
        ser_shift = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_next = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_next = bit_cnt + CNT_WIDTH'(1);
        end
      end
      PARITY: begin
        mux_sel    = MUX_PARITY;
        busy       = 1'b1;
        state_next = STOP;
      end
      STOP: begin
        mux_sel    = MUX_STOP;
        busy       = 1'b1;
        state_next = accept ? START : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with DATA_WIDTH=8.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       par_en;
  logic       ser_load;
  logic       ser_shift;
  logic       par_load;
  logic [1:0] mux_sel;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .par_en     (par_en),
    .ser_load   (ser_load),
    .ser_shift  (ser_shift),
    .par_load   (par_load),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Packed view {ser_load, ser_shift, par_load, mux_sel, busy}.
  localparam logic [5:0] V_IDLE       = 6'b000_01_0;
  localparam logic [5:0] V_ACC_IDLE   = 6'b101_01_0;
  localparam logic [5:0] V_ACC_STOP   = 6'b101_01_1;
  localparam logic [5:0] V_START      = 6'b000_00_1;
  localparam logic [5:0] V_DATA       = 6'b010_10_1;
  localparam logic [5:0] V_PARITY     = 6'b000_11_1;
  localparam logic [5:0] V_STOP       = 6'b000_01_1;

  function automatic logic [5:0] observed();
    return {ser_load, ser_shift, par_load, mux_sel, busy};
  endfunction

  // Hand-derived slot timing of one 8-bit frame whose strobe lands at k=0 from IDLE.
  function automatic logic [5:0] exp_frame(input int k, input logic with_par);
    if (k == 0) return V_ACC_IDLE;
    if (k == 1) return V_START;
    if (k >= 2 && k <= 9) return V_DATA;
    if (with_par) begin
      if (k == 10) return V_PARITY;
      if (k == 11) return V_STOP;
      return V_IDLE;
    end
    if (k == 10) return V_STOP;
    return V_IDLE;
  endfunction

  task automatic settle_idle();
    repeat (3) begin
      @(negedge clk);
      rst        = 1'b0;
      data_valid = 1'b0;
      par_en     = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1; data_valid = 1'b0; par_en = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1 obs = observed();
      tests_run++;
      if (obs !== V_IDLE) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle k=%0d observed=%b expected=%b", k, obs, V_IDLE);
      end
    end
    // Strobes must stay low while reset is asserted, even with a request present.
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b1;
    #1 obs = observed();
    tests_run++;
    if (obs !== V_IDLE) begin
      tests_failed++;
      $display("[TB] FAIL reset_blocks_load observed=%b expected=%b", obs, V_IDLE);
    end
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    #1 obs = observed();
    tests_run++;
    if (obs !== V_IDLE) begin
      tests_failed++;
      $display("[TB] FAIL reset_after_req observed=%b expected=%b", obs, V_IDLE);
    end
  endtask

  task automatic test_frame(input logic with_par);
    logic [5:0] obs, exp;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      data_valid = (k == 0);
      if (k == 0) par_en = with_par;
      if (k == 3) par_en = 1'b0;
      #1 obs = observed();
      exp = exp_frame(k, with_par);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL frame par=%0b k=%0d observed=%b expected=%b", with_par, k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, exp;
    int loads = 0;
    par_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      data_valid = (k <= 20);
      #1 obs = observed();
      if (k == 0)                 exp = V_ACC_IDLE;
      else if (k > 20)            exp = exp_frame(k - 20, 1'b0);
      else if (k % 10 == 0)       exp = V_ACC_STOP;
      else if (k % 10 == 1)       exp = V_START;
      else                        exp = V_DATA;
      if (ser_load) loads++;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back k=%0d observed=%b expected=%b", k, obs, exp);
      end
    end
    tests_run++;
    if (loads !== 3) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_loads observed=%0d expected=3", loads);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] obs, exp;
    par_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst        = (k == 5);
      data_valid = (k == 0) || (k == 7);
      #1 obs = observed();
      if (k <= 5)      exp = exp_frame(k, 1'b0);
      else if (k == 6) exp = V_IDLE;
      else             exp = exp_frame(k - 7, 1'b0);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_frame k=%0d observed=%b expected=%b", k, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ignored_request();
    logic [5:0] obs, exp;
    int loads = 0;
    par_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      data_valid = (k == 0) || (k == 4) || (k == 10);
      #1 obs = observed();
      exp = exp_frame(k, 1'b1);
      if (ser_load) loads++;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL ignored_request k=%0d observed=%b expected=%b", k, obs, exp);
      end
    end
    tests_run++;
    if (loads !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ignored_request_loads observed=%0d expected=1", loads);
    end
  endtask

  initial begin
    test_reset();
    settle_idle();
    test_frame(1'b0);
    settle_idle();
    test_frame(1'b1);
    settle_idle();
    test_back_to_back();
    settle_idle();
    test_reset_mid_frame();
    settle_idle();
    test_ignored_request();
    settle_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
